// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch write sequencer.
//   seq_state_e : sequencer FSM states
//   cnt_width() : interval counter width, sized for the longest interval
package latch_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold
  } seq_state_e;

  // The counter only ever holds (interval - 1), so clog2 of the largest interval is enough.
  // It is kept at least 1 bit wide so the counter stays a legal vector when all intervals are 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears to 0)
//   load_i        : load load_val_i (has priority over decrement)
//   load_val_i    : value to load
//   dec_i         : decrement by one when non-zero
//   zero_o        : count is zero
module cycle_down_counter #(
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_wr_sequencer.sv
// Upstream driver for a bank of level-sensitive D latches. Accepts a word over valid/ready,
// presents it on lat_d_o and opens lat_en_o for PULSE_CYC cycles, with SETUP_CYC cycles of
// data stability before and HOLD_CYC cycles after, so the data never moves while the latches
// are transparent.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   in_valid_i    : upstream word available
//   in_ready_o    : sequencer idle and able to accept (decode of the idle state)
//   in_data_i     : word to write
//   lat_d_o       : latch-bank data, held from acceptance until the sequence ends
//   lat_en_o      : latch-bank enable, single clean pulse per write
//   busy_o        : write sequence in progress
//   done_o        : one-cycle completion pulse
//   wr_count_o    : completed writes, wraps silently
module latch_wr_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic [WIDTH-1:0] lat_d_o,
  output logic             lat_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] wr_count_o
);

  localparam int CntW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  if (SETUP_CYC < 1) begin : gen_bad_setup
    $error("latch_wr_sequencer: SETUP_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : gen_bad_pulse
    $error("latch_wr_sequencer: PULSE_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : gen_bad_hold
    $error("latch_wr_sequencer: HOLD_CYC must be at least 1");
  end

  seq_state_e       state_q;
  logic [WIDTH-1:0] lat_d_q;
  logic             lat_en_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] wr_count_q;

  logic            accept;
  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_dec;
  logic            cnt_zero;

  assign in_ready_o = (state_q == StIdle);
  assign accept     = in_valid_i & in_ready_o;

  // Every state entry reloads the counter with (interval - 1); zero marks the last cycle.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(PULSE_CYC - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(HOLD_CYC - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHold: begin
        cnt_dec = ~cnt_zero;
      end
      default: ;
    endcase
  end

  cycle_down_counter #(
    .Width (CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // The idle cycle that carries done is also the next accept opportunity, so back-to-back
  // writes start SETUP_CYC + PULSE_CYC + HOLD_CYC + 1 cycles apart.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lat_d_q    <= '0;
      lat_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            lat_d_q <= in_data_i;
            busy_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_zero) begin
            lat_en_q <= 1'b1;
            state_q  <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_zero) begin
            lat_en_q <= 1'b0;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (cnt_zero) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            wr_count_q <= wr_count_q + CNT_W'(1);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lat_d_o    = lat_d_q;
  assign lat_en_o   = lat_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_count_o = wr_count_q;

endmodule
